// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial pattern generator and the 1011 detector.
// Holds the FSM state encodings and the default 1011 pattern.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3
  } state_e;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/sequence_generator_if.sv
// Command/serial-output bundle of the sequence generator.
// The abort strobe exists only when SEQ_GEN_ABORT_EN is defined.
interface sequence_generator_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
`ifdef SEQ_GEN_ABORT_EN
  logic             abort;
`endif
  logic             data_out;
  logic             valid_out;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_cnt, gap_len,
    input  data_out, valid_out, busy, done
`ifdef SEQ_GEN_ABORT_EN
    , output abort
`endif
  );

  modport slave (
    input  start, repeat_cnt, gap_len,
    output data_out, valid_out, busy, done
`ifdef SEQ_GEN_ABORT_EN
    , input abort
`endif
  );
endinterface

// File: rtl/seq_shift_reg.sv
// PAT_W-wide parallel-load MSB-first shift register with a bit index down-counter.
// bit_d is the serial bit that will sit at the MSB after this edge.
module seq_shift_reg #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic last,
  output logic bit_d
);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    bit_d = sr_q[PAT_W-1];
    if (load) begin
      sr_d  = PATTERN;
      idx_d = IDX_W'(PAT_W-1);
      bit_d = PATTERN[PAT_W-1];
    end else if (shift) begin
      sr_d  = {sr_q[PAT_W-2:0], 1'b0};
      idx_d = idx_q - IDX_W'(1);
      bit_d = sr_q[PAT_W-2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign last = (idx_q == '0);
endmodule

// File: rtl/sequence_generator.sv
// Moore serial pattern transmitter: sends PATTERN MSB first, repeat_cnt times, gap_len zeros between.
// Optional abort input enabled by defining SEQ_GEN_ABORT_EN.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1011,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_generator_if.slave  bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, last, bit_d;
  logic             abort_req;

`ifdef SEQ_GEN_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  seq_shift_reg #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .last  (last),
    .bit_d (bit_d)
  );

  // rem_q counts repeats still owed after the one currently on the wire.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        gap_len_d = bus.gap_len;
        if (bus.repeat_cnt != '0) begin
          rem_d   = bus.repeat_cnt - CNT_W'(1);
          state_d = SHIFT;
          load    = 1'b1;
        end else begin
          rem_d   = '0;
          state_d = DONE;
        end
      end
      SHIFT: begin
        if (!last) begin
          shift = 1'b1;
        end else if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
          if (gap_len_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_W'(1);
          end else begin
            load = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (gap_cnt_q == gap_len_q) begin
          state_d = SHIFT;
          load    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_req && (state_q == SHIFT || state_q == GAP)) begin
      state_d = IDLE;
      load    = 1'b0;
      shift   = 1'b0;
    end

    valid_d    = (state_d == SHIFT);
    data_out_d = valid_d & bit_d;
    busy_d     = (state_d == SHIFT) || (state_d == GAP);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      gap_len_q  <= '0;
      gap_cnt_q  <= '0;
      data_out_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      gap_len_q  <= gap_len_d;
      gap_cnt_q  <= gap_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
